beta_imem_responder: RTL and testbench



---
 rtl/beta_imem_pkg.sv | 22 ++
 rtl/beta_imem_resp_pipe.sv | 52 +++++
 rtl/beta_imem_responder.sv | 87 ++++++++
 tb/tb_beta_imem_responder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beta_imem_pkg.sv
// Shared types, limits and parameter checks for the instruction-memory responder.
package beta_imem_pkg;

  localparam int unsigned IMEM_MAX_LATENCY     = 7;
  localparam int unsigned IMEM_MAX_OUTSTANDING = 8;
  localparam int unsigned IMEM_DEFAULT_DATA_W  = 32;

  // Response record as carried through the response pipe at the default word width.
  typedef struct packed {
    logic                           valid;
    logic                           err;
    logic [IMEM_DEFAULT_DATA_W-1:0] data;
  } imem_resp_t;

  // Elaboration-time range check for the latency / outstanding parameters.
  function automatic bit imem_params_ok(input int unsigned latency,
                                        input int unsigned max_outstanding);
    return (latency >= 1) && (latency <= IMEM_MAX_LATENCY) &&
           (max_outstanding >= 1) && (max_outstanding <= IMEM_MAX_OUTSTANDING);
  endfunction

endpackage

// File: rtl/beta_imem_resp_pipe.sv
// Latency-deep response shift register; flush clears every valid bit except a same-edge push.
module beta_imem_resp_pipe #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Latency   = 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic                 push_err_i,
  input  logic [DataWidth-1:0] push_data_i,
  output logic                 out_valid_o,
  output logic                 out_err_o,
  output logic [DataWidth-1:0] out_data_o
);

  typedef struct packed {
    logic                 valid;
    logic                 err;
    logic [DataWidth-1:0] data;
  } resp_t;

  resp_t stage_q [Latency];

  // Shift entries toward the output; payload only moves with a valid entry so the
  // output data/err hold their last delivered value while idle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < Latency; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      if (push_i) begin
        stage_q[0] <= '{valid: 1'b1, err: push_err_i, data: push_data_i};
      end else begin
        stage_q[0].valid <= 1'b0;
      end
      for (int unsigned i = 1; i < Latency; i++) begin
        if (stage_q[i-1].valid && !flush_i) begin
          stage_q[i] <= stage_q[i-1];
        end else begin
          stage_q[i].valid <= 1'b0;
        end
      end
    end
  end

  assign out_valid_o = stage_q[Latency-1].valid;
  assign out_err_o   = stage_q[Latency-1].err;
  assign out_data_o  = stage_q[Latency-1].data;

endmodule

// File: rtl/beta_imem_responder.sv
// Instruction-memory responder: fixed-latency word reads, outstanding limit, flush, program load.
module beta_imem_responder
  import beta_imem_pkg::*;
#(
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned MemDepth       = 1024,
  parameter int unsigned Latency        = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        imem_req_i,
  input  logic [AddrWidth-1:0]        imem_addr_i,
  output logic                        imem_ready_o,
  output logic                        imem_valid_o,
  output logic [DataWidth-1:0]        imem_rdata_o,
  output logic                        imem_err_o,
  input  logic                        imem_flush_i,
  input  logic                        ld_en_i,
  input  logic [$clog2(MemDepth)-1:0] ld_addr_i,
  input  logic [DataWidth-1:0]        ld_data_i
);

  localparam int unsigned IdxW  = $clog2(MemDepth);
  localparam int unsigned WordW = AddrWidth - 2;
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);
  localparam logic [WordW-1:0] DepthWords = WordW'(MemDepth);
  localparam logic [CntW-1:0]  CntMax     = CntW'(MaxOutstanding);

  if (!imem_params_ok(Latency, MaxOutstanding)) begin : g_param_check
    $error("beta_imem_responder: Latency must be 1..7 and MaxOutstanding 1..8");
  end

  logic [DataWidth-1:0] mem [MemDepth];
  logic [CntW-1:0]      cnt_q;
  logic [WordW-1:0]     word_idx;
  logic [DataWidth-1:0] rd_word;
  logic                 addr_err;
  logic                 accept;
  logic                 pipe_valid;

  assign imem_ready_o = !ld_en_i && (cnt_q < CntMax);
  assign accept       = imem_req_i && imem_ready_o;

  assign word_idx = imem_addr_i[AddrWidth-1:2];
  assign addr_err = (imem_addr_i[1:0] != 2'b00) || (word_idx >= DepthWords);
  assign rd_word  = addr_err ? '0 : mem[word_idx[IdxW-1:0]];

  // In-flight count: flush restarts from the surviving same-edge accept, if any.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (imem_flush_i) begin
      cnt_q <= accept ? CntW'(1) : '0;
    end else if (accept && !pipe_valid) begin
      cnt_q <= cnt_q + CntW'(1);
    end else if (!accept && pipe_valid) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  // Program-load write port; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (ld_en_i) begin
      mem[ld_addr_i] <= ld_data_i;
    end
  end

  beta_imem_resp_pipe #(
    .DataWidth (DataWidth),
    .Latency   (Latency)
  ) u_resp_pipe (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .flush_i     (imem_flush_i),
    .push_i      (accept),
    .push_err_i  (addr_err),
    .push_data_i (rd_word),
    .out_valid_o (pipe_valid),
    .out_err_o   (imem_err_o),
    .out_data_o  (imem_rdata_o)
  );

  assign imem_valid_o = pipe_valid && !imem_flush_i;

endmodule

// File: tb/tb_beta_imem_responder.sv
// Bench for beta_imem_responder: instance 0 uses Latency=1, instance 1 uses Latency=3.
module tb_beta_imem_responder;

  localparam int unsigned MO   = 2;
  localparam int unsigned HMAX = 4096;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req   [2];
  logic [31:0] addr  [2];
  logic        ready [2];
  logic        valid [2];
  logic [31:0] rdata [2];
  logic        err   [2];
  logic        flush [2];
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  always #5 clk = ~clk;

  beta_imem_responder #(
    .DataWidth(32), .AddrWidth(32), .MemDepth(1024), .Latency(1), .MaxOutstanding(MO)
  ) dut0 (
    .clk_i(clk), .rstn_i(rstn), .imem_req_i(req[0]), .imem_addr_i(addr[0]),
    .imem_ready_o(ready[0]), .imem_valid_o(valid[0]), .imem_rdata_o(rdata[0]),
    .imem_err_o(err[0]), .imem_flush_i(flush[0]), .ld_en_i(ld_en),
    .ld_addr_i(ld_addr), .ld_data_i(ld_data)
  );

  beta_imem_responder #(
    .DataWidth(32), .AddrWidth(32), .MemDepth(1024), .Latency(3), .MaxOutstanding(MO)
  ) dut1 (
    .clk_i(clk), .rstn_i(rstn), .imem_req_i(req[1]), .imem_addr_i(addr[1]),
    .imem_ready_o(ready[1]), .imem_valid_o(valid[1]), .imem_rdata_o(rdata[1]),
    .imem_err_o(err[1]), .imem_flush_i(flush[1]), .ld_en_i(ld_en),
    .ld_addr_i(ld_addr), .ld_data_i(ld_data)
  );

  // Reference model: responses scheduled by the cycle they must appear in.
  bit          ev   [2][HMAX];
  logic [31:0] ed   [2][HMAX];
  bit          ee   [2][HMAX];
  int          pend [2];
  bit          last_acc [2];
  logic [31:0] mem_m [64];
  int          cyc = 0;

  logic [31:0] got_d [2][512];
  bit          got_e [2][512];
  int          got_n [2];

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock cycle: check outputs mid-cycle against the model, then advance the model.
  task automatic tick();
    bit acc [2];
    #2;
    for (int u = 0; u < 2; u++) begin
      bit er;
      bit ev_now;
      er     = !ld_en && (pend[u] < MO);
      ev_now = ev[u][cyc] && !flush[u];
      chk($sformatf("u%0d_ready", u), 32'(ready[u]), 32'(er));
      chk($sformatf("u%0d_valid", u), 32'(valid[u]), 32'(ev_now));
      if (ev_now && valid[u]) begin
        chk($sformatf("u%0d_rdata", u), rdata[u], ed[u][cyc]);
        chk($sformatf("u%0d_err", u), 32'(err[u]), 32'(ee[u][cyc]));
      end
      if (valid[u] && got_n[u] < 512) begin
        got_d[u][got_n[u]] = rdata[u];
        got_e[u][got_n[u]] = err[u];
        got_n[u]++;
      end
      acc[u] = req[u] && er && rstn;
    end
    @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      int lat;
      bit    a_err;
      lat = (u == 0) ? 1 : 3;
      if (ev[u][cyc]) pend[u]--;
      if (flush[u]) begin
        for (int k = cyc + 1; k < cyc + 10; k++) ev[u][k] = 1'b0;
        pend[u] = 0;
      end
      if (acc[u]) begin
        a_err = (addr[u][1:0] != 2'b00) || (addr[u][31:2] >= 30'd1024);
        ev[u][cyc + lat] = 1'b1;
        ee[u][cyc + lat] = a_err;
        ed[u][cyc + lat] = a_err ? 32'h0 : mem_m[addr[u][7:2]];
        pend[u]++;
      end
      last_acc[u] = acc[u];
    end
    if (ld_en) mem_m[ld_addr[5:0]] = ld_data;
    cyc++;
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Hold a request until the model says it was accepted, bounded.
  task automatic issue(input int u, input logic [31:0] a, input bit fl);
    int n = 0;
    req[u] = 1'b1;
    addr[u] = a;
    flush[u] = fl;
    do begin
      tick();
      flush[u] = 1'b0;
      n++;
    end while (!last_acc[u] && n < 20);
    chk($sformatf("u%0d_issue_accepted", u), 32'(last_acc[u]), 32'd1);
    req[u] = 1'b0;
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    ld_en = 1'b1;
    ld_addr = 10'(idx);
    ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic async_reset();
    rstn = 1'b0;
    req[0] = 1'b0;
    req[1] = 1'b0;
    for (int u = 0; u < 2; u++) begin
      pend[u] = 0;
      for (int k = cyc; k < cyc + 10; k++) ev[u][k] = 1'b0;
    end
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d_rst_valid", u), 32'(valid[u]), 32'd0);
      chk($sformatf("u%0d_rst_rdata", u), rdata[u], 32'd0);
      chk($sformatf("u%0d_rst_err", u), 32'(err[u]), 32'd0);
    end
    tick();
    tick();
    rstn = 1'b1;
    tick();
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d_post_rst_rdata", u), rdata[u], 32'd0);
      chk($sformatf("u%0d_post_rst_ready", u), 32'(ready[u]), 32'd1);
    end
  endtask

  task automatic run_table(input int u);
    int base;
    base = got_n[u];
    for (int k = 0; k < 6; k++) issue(u, tbl[k].a, 1'b0);
    drain(6);
    chk($sformatf("u%0d_tbl_count", u), 32'(got_n[u] - base), 32'd6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("u%0d_tbl%0d_data", u, k), got_d[u][base + k], tbl[k].exp_data);
      chk($sformatf("u%0d_tbl%0d_err", u, k), 32'(got_e[u][base + k]), 32'(tbl[k].exp_err));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    tbl[0] = '{32'h0000_0000, 32'h0000_0013, 1'b0};
    tbl[1] = '{32'h0000_0004, 32'h0010_0093, 1'b0};
    tbl[2] = '{32'h0000_0008, 32'h0020_0113, 1'b0};
    tbl[3] = '{32'h0000_000C, 32'h0030_0193, 1'b0};
    tbl[4] = '{32'h0000_0002, 32'h0000_0000, 1'b1};
    tbl[5] = '{32'h0000_1000, 32'h0000_0000, 1'b1};

    rstn = 1'b0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    for (int u = 0; u < 2; u++) begin
      req[u] = 1'b0;
      addr[u] = '0;
      flush[u] = 1'b0;
      pend[u] = 0;
      got_n[u] = 0;
    end
    #6;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d_reset_valid", u), 32'(valid[u]), 32'd0);
      chk($sformatf("u%0d_reset_rdata", u), rdata[u], 32'd0);
      chk($sformatf("u%0d_reset_err", u), 32'(err[u]), 32'd0);
      chk($sformatf("u%0d_reset_ready", u), 32'(ready[u]), 32'd1);
    end
    rstn = 1'b1;

    // Program preload
    load(0, 32'h0000_0013);
    load(1, 32'h0010_0093);
    load(2, 32'h0020_0113);
    load(3, 32'h0030_0193);
    for (int i = 4; i < 64; i++) load(i, $urandom);

    // Back-to-back fetches and error cases, both latencies
    run_table(0);
    run_table(1);

    // Flush on the edge that accepts the next request: only that one survives
    base = got_n[1];
    issue(1, 32'h0, 1'b0);
    issue(1, 32'h4, 1'b1);
    issue(1, 32'h8, 1'b0);
    drain(6);
    chk("flush_resp_count", 32'(got_n[1] - base), 32'd2);
    chk("flush_survivor", got_d[1][base], 32'h0010_0093);
    chk("flush_next", got_d[1][base + 1], 32'h0020_0113);

    // Load while a request is pending and an earlier response is in flight
    base = got_n[1];
    issue(1, 32'h8, 1'b0);
    ld_en = 1'b1;
    ld_addr = 10'd4;
    ld_data = 32'hDEAD_BEEF;
    req[1] = 1'b1;
    addr[1] = 32'h10;
    drain(3);
    ld_en = 1'b0;
    issue(1, 32'h10, 1'b0);
    drain(5);
    chk("load_resp_count", 32'(got_n[1] - base), 32'd2);
    chk("load_inflight", got_d[1][base], 32'h0020_0113);
    chk("load_new_word", got_d[1][base + 1], 32'hDEAD_BEEF);

    // Asynchronous reset between accept and response
    base = got_n[0] + got_n[1];
    req[0] = 1'b1;
    addr[0] = 32'h4;
    req[1] = 1'b1;
    addr[1] = 32'h8;
    tick();
    async_reset();
    drain(5);
    chk("rst_no_resp", 32'(got_n[0] + got_n[1] - base), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int u = 0; u < 2; u++) begin
        int r;
        r = $urandom_range(0, 9);
        req[u] = 1'($urandom_range(0, 1));
        flush[u] = ($urandom_range(0, 15) == 0);
        if (r == 0) addr[u] = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
        else if (r == 1) addr[u] = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
        else addr[u] = 32'($urandom_range(0, 63)) << 2;
      end
      ld_en = ($urandom_range(0, 31) == 0);
      ld_addr = 10'($urandom_range(8, 63));
      ld_data = $urandom;
      tick();
    end
    for (int u = 0; u < 2; u++) begin
      req[u] = 1'b0;
      flush[u] = 1'b0;
    end
    ld_en = 1'b0;
    drain(6);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
